// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Scan-result and debounce-state encodings live here.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_e;

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    return {2'b0, v[0]} + {2'b0, v[1]}
         + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  function automatic logic [1:0] low_index4(
    input logic [3:0] v
  );
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debounce FSM plus the key output register
// with its valid/ready handshake and sticky overflow.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scan_done,
  input  scan_res_e         scan_res,
  input  logic [CODE_W-1:0] scan_code,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key,
  output logic              key_valid,
  output logic              key_held,
  output logic              overflow
);

  localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [NW-1:0] N_LAST = NW'(DEBOUNCE_SCANS);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  db_state_e         state_q, state_d;
  logic [NW-1:0]     n_q, n_d, n_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] key_q, key_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              accept, hs;
  logic              is_none, is_single;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cand_d    = cand_q;
    accept    = 1'b0;
    n_inc     = n_q + 1'b1;
    is_none   = (scan_res == RES_NONE);
    is_single = (scan_res == RES_SINGLE);
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = scan_code;
            if (N_ONE == N_LAST) begin
              accept  = 1'b1;
              state_d = HELD;
              n_d     = '0;
            end else begin
              state_d = PRESS_WAIT;
              n_d     = N_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (is_single && scan_code == cand_q) begin
            if (n_inc == N_LAST) begin
              accept  = 1'b1;
              state_d = HELD;
              n_d     = '0;
            end else begin
              n_d = n_inc;
            end
          end else begin
            state_d = IDLE;
            n_d     = '0;
          end
        end
        HELD: begin
          if (is_none) begin
            if (N_ONE == N_LAST) begin
              state_d = IDLE;
              n_d     = '0;
            end else begin
              state_d = RELEASE_WAIT;
              n_d     = N_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (is_none) begin
            if (n_inc == N_LAST) begin
              state_d = IDLE;
              n_d     = '0;
            end else begin
              n_d = n_inc;
            end
          end else begin
            state_d = HELD;
            n_d     = '0;
          end
        end
        default: begin
          state_d = IDLE;
          n_d     = '0;
        end
      endcase
    end
  end

  // A handshake in the accept cycle absorbs the old code: no overflow.
  always_comb begin
    hs      = valid_q & key_ready;
    key_d   = key_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (accept) begin
      key_d   = scan_code;
      valid_d = 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    if (accept && valid_q && !hs) begin
      ovf_d = 1'b1;
    end else if (hs) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      n_q     <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key       = key_q;
  assign key_valid = valid_q;
  assign overflow  = ovf_q;
  assign key_held  = (state_q == HELD)
                  || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: column synchronizer, slot/row
// counters and per-scan key accumulation feeding the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [NUM_ROWS-1:0] rows,
  input  logic [NUM_COLS-1:0] cols,
  output logic [CODE_W-1:0]   key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overflow
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(SCAN_DIV - 1);

  logic [NUM_COLS-1:0] sync1_q, sync2_q;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          row_q, row_d;
  logic                one_q, one_d;
  logic                multi_q, multi_d;
  logic [CODE_W-1:0]   code_q, code_d;

  logic                tc, scan_done;
  logic [NUM_COLS-1:0] act;
  logic [2:0]          pc;
  logic                new_one, new_multi;
  logic [CODE_W-1:0]   new_code;
  scan_res_e           scan_res;

  always_comb begin
    tc        = (slot_q == SLOT_LAST);
    act       = ~sync2_q;
    pc        = popcount4(act);
    new_multi = multi_q | (pc > 3'd1)
              | (one_q & (pc != 3'd0));
    new_one   = ~new_multi & (one_q | (pc == 3'd1));
    new_code  = one_q ? code_q
                      : {row_q, low_index4(act)};
    slot_d    = tc ? '0 : slot_q + 1'b1;
    row_d     = tc ? row_q + 2'd1 : row_q;
    one_d     = one_q;
    multi_d   = multi_q;
    code_d    = code_q;
    scan_done = 1'b0;
    if (tc) begin
      if (row_q == 2'd3) begin
        scan_done = 1'b1;
        one_d     = 1'b0;
        multi_d   = 1'b0;
        code_d    = '0;
      end else begin
        one_d   = new_one;
        multi_d = new_multi;
        code_d  = new_code;
      end
    end
    if (new_multi) scan_res = RES_MULTI;
    else if (new_one) scan_res = RES_SINGLE;
    else scan_res = RES_NONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      slot_q  <= '0;
      row_q   <= '0;
      one_q   <= 1'b0;
      multi_q <= 1'b0;
      code_q  <= '0;
    end else begin
      sync1_q <= cols;
      sync2_q <= sync1_q;
      slot_q  <= slot_d;
      row_q   <= row_d;
      one_q   <= one_d;
      multi_q <= multi_d;
      code_q  <= code_d;
    end
  end

  assign rows = ~(4'b0001 << row_q);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .scan_done (scan_done),
    .scan_res  (scan_res),
    .scan_code (new_code),
    .key_ready (key_ready),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives cols,
// a scan-level reference model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int DS = 2;

  logic        clk;
  logic        resetn;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overflow;

  logic [15:0] pressed;

  int          n_asrt;
  int          n_fail;

  logic [3:0]  m_key;
  logic        m_valid;
  logic        m_ovf;
  logic        m_down;
  int          m_run;
  logic [3:0]  m_cand;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c while pressed.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && pressed[r*4+c])
          cols[c] = 1'b0;
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("key", 16'(key), 16'(m_key));
    chk("key_valid", 16'(key_valid), 16'(m_valid));
    chk("key_held", 16'(key_held), 16'(m_down));
    chk("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  task automatic model_reset();
    m_key   = 4'h0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_down  = 1'b0;
    m_run   = 0;
    m_cand  = 4'h0;
  endtask

  task automatic model_scan(
    input logic [15:0] p,
    input bit          rdy
  );
    int         cnt;
    int         idx;
    bit         acc;
    bit         hs;
    logic [3:0] c;
    cnt = $countones(p);
    idx = 0;
    for (int i = 0; i < 16; i++)
      if (p[i]) idx = i;
    c   = 4'(idx);
    acc = 1'b0;
    if (!m_down) begin
      if (cnt == 1 && (m_run == 0 || m_cand == c)) begin
        m_run++;
        m_cand = c;
        if (m_run == DS) begin
          acc    = 1'b1;
          m_down = 1'b1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (cnt == 0) begin
        m_run++;
        if (m_run == DS) begin
          m_down = 1'b0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    hs = rdy && m_valid;
    if (acc) begin
      if (m_valid && !hs) m_ovf = 1'b1;
      else if (hs) m_ovf = 1'b0;
      m_valid = 1'b1;
      m_key   = c;
    end else if (hs) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  // One full scan; entered and left just after a falling edge.
  task automatic do_scan(
    input logic [15:0] p,
    input bit          pulse,
    input bit          rdy_end
  );
    logic [3:0] er;
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) pressed = p;
      key_ready = (k == 1)  ? pulse :
                  (k == 16) ? rdy_end : 1'b0;
      @(posedge clk);
      #1;
      if (k == 1 && pulse && m_valid) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end
      if (k == 16) model_scan(p, rdy_end);
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("rows", 16'(rows), 16'(er));
      chk_outs();
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] one;
    int          a;
    int          b;
    int          s;
    n_asrt    = 0;
    n_fail    = 0;
    one       = 16'h0001;
    pressed   = 16'h0;
    key_ready = 1'b0;
    resetn    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rows", 16'(rows), 16'h000E);
    chk_outs();
    @(negedge clk);
    resetn = 1'b1;

    do_scan(16'h0, 0, 0);
    do_scan(16'h0, 0, 0);

    repeat (3) do_scan(one << 9, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);
    do_scan(16'h0, 1, 0);

    do_scan(one << 3, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);

    repeat (3) begin
      do_scan(one << 6, 0, 0);
      do_scan(16'h0, 0, 0);
    end

    repeat (3) do_scan(16'h0009, 0, 0);
    do_scan(16'h0, 0, 0);

    repeat (2) do_scan(one << 5, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);
    repeat (2) do_scan(one << 10, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);
    do_scan(16'h0, 1, 0);

    repeat (2) do_scan(one << 5, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);
    do_scan(one << 12, 0, 0);
    do_scan(one << 12, 0, 1);
    repeat (2) do_scan(16'h0, 0, 0);

    do_scan(one << 7, 0, 0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("mid_reset_rows", 16'(rows), 16'h000E);
    chk_outs();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) do_scan(one << 7, 0, 0);
    repeat (2) do_scan(16'h0, 0, 0);

    p = 16'h0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 99) >= 55) begin
        s = $urandom_range(0, 99);
        a = $urandom_range(0, 15);
        if (s < 40) begin
          p = 16'h0;
        end else if (s < 85) begin
          p = one << a;
        end else begin
          b = (a + 1 + $urandom_range(0, 14)) % 16;
          p = (one << a) | (one << b);
        end
      end
      do_scan(p,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 membrane keypad on a PMOD-style tile by driving one row low at a time and sampling the four column lines. It debounces presses over whole scans and presents each newly pressed key as a 4-bit code on a valid/ready handshake. It is the input-side companion to the multiplexed 7-segment output path: top level routes `rows`/`cols` to a tile and the key code into the display or control logic.

## Interface
- `SCAN_DIV`, 25000, clk cycles per row slot (1 ms at 25 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, 4, consecutive identical full scans required to accept a press or a release; must be ≥ 1.

- `clk` in 1: 25 MHz system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `rows` out 4: row strobes, active-low one-hot (exactly one bit 0).
- `cols` in 4: column sense, active-low (board pull-ups), asynchronous to `clk`.
- `key` out 4: code of the last accepted press, `{row[1:0], col[1:0]}`.
- `key_valid` out 1: `key` holds an unconsumed code.
- `key_ready` in 1: consumer accepts `key` when high with `key_valid`.
- `key_held` out 1: a debounced key is currently down.
- `overflow` out 1: sticky; a press was accepted while `key_valid` was pending.

## Operation
- `cols` pass through a 2-flop synchronizer before any use.
- Slot counter counts 0..SCAN_DIV-1. On terminal count it advances the row index 0→1→2→3→0. `rows` = ~(1 << row index).
- Columns are sampled only on the terminal-count cycle of each slot. This gives SCAN_DIV-1 cycles of settle time, covering the synchronizer.
- Per scan (rows 0..3) the samples are accumulated:
  - zero active bits gives NONE;
  - exactly one active bit gives SINGLE(code);
  - more than one gives MULTI.
- Scan result is evaluated on the terminal cycle of row 3.
- Debounce FSM, with scan counter `n`:
  - IDLE: SINGLE(c) → PRESS_WAIT, candidate=c, n=1. Any other result stays in IDLE.
  - PRESS_WAIT: SINGLE(same c) → n+1; when n reaches DEBOUNCE_SCANS, accept c and go to HELD. Any other result → IDLE.
  - HELD: NONE → RELEASE_WAIT, n=1. SINGLE(c) and MULTI stay in HELD; no new report.
  - RELEASE_WAIT: NONE → n+1; when n reaches DEBOUNCE_SCANS, go to IDLE. Any non-NONE result → HELD.
  - With DEBOUNCE_SCANS=1, the first qualifying scan accepts or releases directly.
- Accept:
  - `key`←c and `key_valid`←1.
  - If `key_valid` was 1 and no handshake occurs in that same cycle, `overflow`←1. The newest code overwrites the pending one.
- Handshake: `key_valid & key_ready` clears `key_valid` next cycle.
  - If accept coincides with a handshake, `key_valid` stays 1 with the new code and no overflow is raised.
  - `overflow` clears on a handshake cycle unless it is set in that same cycle; set wins.
- `key_held` = state ∈ {HELD, RELEASE_WAIT}.

## Timing
- Reset values:
  - `rows`=4'b1110;
  - slot counter and row index 0;
  - FSM in IDLE, n=0;
  - `key`=0, `key_valid`=0, `key_held`=0, `overflow`=0;
  - synchronizer flops=4'b1111 (idle).
- A reset mid-scan or mid-debounce discards all partial state. No report is generated.
- Scan period = 4·SCAN_DIV cycles.
- `key_valid` rises 1 cycle after the row-3 sample closing the DEBOUNCE_SCANS-th qualifying scan.
- Minimum press-to-valid latency: DEBOUNCE_SCANS scans, plus up to one partial scan.
- `key_held` changes on the same edge as the corresponding FSM transition.
- `key` is stable whenever `key_valid` is high, except on an overwrite.
- `key_ready` may be held high permanently.

## Structure
- `keypad_pkg`: NUM_ROWS=4, NUM_COLS=4, CODE_W=4, the state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), and the scan-result encoding (NONE, SINGLE, MULTI).
- Sub-module `keypad_debounce`: the FSM, scan counter and output register/handshake.
- Top level `keypad_scanner`: synchronizer, slot/row counters and per-scan accumulation.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2 (scan = 16 cycles).
- Reset → `rows` cycles 1110,1101,1011,0111 every 4 cycles. All outputs hold their reset values with `cols`=1111.
- Hold row 2 / col 1 down ≥ 3 scans with `key_ready`=0:
  - `key`=4'h9, `key_valid`=1, `key_held`=1;
  - after release for 2 scans, `key_held`=0 and `key_valid` is still 1.
- Press lasting exactly 1 scan → no `key_valid`.
- Bounce (press/release alternating per scan) → no `key_valid`.
- Two keys down together (row 0 / col 0 and row 0 / col 3) → no report, FSM stays in IDLE.
- With `key_ready`=0, press 0x5, release, then press 0xA:
  - `overflow`=1, `key`=0xA;
  - pulse `key_ready` → `key_valid`=0 and `overflow`=0 next cycle.
- Assert `resetn`=0 during PRESS_WAIT → outputs return to reset values immediately. A press after release of reset needs 2 full scans again.
